x4_frame_reader: RTL
====================

X4_FRAME_READER -- requirements
Module: x4_frame_reader

Interface
REQ-001 Parameters: FRAME_BINS, 188, samples per radar frame.
REQ-002 Parameters: FIFO_ADDR, 8'h31, X4 frame-FIFO register address.
REQ-003 Parameters: TIMEOUT, 4096, max clk cycles waiting for any SPI done.
REQ-004 clk  in  1  system clock (clk_100m domain); one clock, all logic rising-edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 enable  in  1  arms frame capture; sampled only in IDLE.
REQ-007 x4_isr  in  1  X4 frame-ready, asynchronous; 2-FF synchronised, rising edge used.
REQ-008 spi_cs  out  1  chip select to spi_module, active-low, low for whole burst.
REQ-009 spi_tx_en / spi_rx_en  out  1 each  byte-transfer requests to spi_module.
REQ-010 spi_data_in  out  8  byte to transmit.
REQ-011 spi_data_out  in  8  received byte; spi_tx_done / spi_rx_done  in  1 each  byte complete.
REQ-012 x4data_valid  out  1  one-cycle sample strobe; x4data_data  out  25  signed sample.
REQ-013 frame_sop / frame_eop  out  1 each  coincide with valid of first / last sample.
REQ-014 x4data_isr2mcu  out  1  frame-complete pulse to MCU; spi_err  out  1  timeout pulse; busy  out  1.

Function
REQ-015 FSM states: IDLE, ADDR, ADDR_WAIT, RX, RX_WAIT, EMIT, DONE.
REQ-016 IDLE -> ADDR on synchronised isr rising edge while enable=1; spi_cs driven 0 on entry to ADDR, busy=1.
REQ-017 ADDR: spi_data_in = 8'h80 | FIFO_ADDR, spi_tx_en=1; held until spi_tx_done sampled high (ADDR_WAIT), deasserted next cycle.
REQ-018 RX: spi_rx_en=1 held until spi_rx_done sampled high; spi_data_out captured that same cycle.
REQ-019 Bytes MSB first; three bytes per sample packed as {b0,b1,b2}, 24-bit two's complement, sign-extended to 25 bits.
REQ-020 x4data_valid asserted the cycle after the third byte's spi_rx_done; x4data_data stable that cycle, held until next valid.
REQ-021 Byte counter wraps 0..2; sample counter counts 0..FRAME_BINS-1; after last sample's EMIT -> DONE.
REQ-022 DONE: spi_cs=1, x4data_isr2mcu pulses high exactly one cycle, busy=0 next cycle, -> IDLE.
REQ-023 Exactly FRAME_BINS valid strobes per frame; sop on first, eop on last; FRAME_BINS=1 asserts both together.
REQ-024 isr edges while busy are ignored (no restart, no corruption).
REQ-025 enable deassertion mid-frame does not abort; current frame completes.
REQ-026 Any wait state exceeding TIMEOUT cycles: spi_err one-cycle pulse, spi_cs=1, tx/rx_en=0, no eop, no isr2mcu, -> IDLE.
REQ-027 Simultaneous isr edge and DONE: edge ignored.

Reset
REQ-028 rst=1 asynchronously forces IDLE, clears counters and sync flops; outputs: spi_cs=1, all others 0, x4data_data=0.
REQ-029 Reset mid-frame abandons the frame; first post-reset frame requires a fresh isr edge.

Configuration
REQ-030 Macro X4_OVERRUN_DET_EN: when defined, adds output overrun_cnt (8-bit, saturating at 255) counting isr edges ignored while busy, cleared by rst only.
REQ-031 Without X4_OVERRUN_DET_EN: port and counter absent; REQ-024 behaviour unchanged.

Verification
REQ-032 FRAME_BINS=4, isr edge, SPI model returns bytes 00 00 01, FF FF FF, 7F FF FF, 80 00 00 -> valids 25'h0000001, 25'h1FFFFFF, 25'h07FFFFF, 25'h1800000; sop on 1st, eop on 4th, one isr2mcu pulse.
REQ-033 First transmitted byte = 8'hB1; spi_cs low from ADDR to DONE, never toggles mid-burst.
REQ-034 Model withholds spi_rx_done on byte 5 -> spi_err pulse after 4096 cycles, spi_cs=1, no eop, next isr edge yields a complete frame.
REQ-035 Three isr edges during one frame (macro defined) -> overrun_cnt=3, frame data intact; macro undefined -> compiles without port.
REQ-036 rst asserted at sample 2 -> outputs at reset values same cycle; after release, enable=0 plus isr edge -> no SPI activity.

Source files
------------

// File: rtl/x4_frame_reader.sv
// x4_frame_reader
// Reads one radar frame from the X4 frame FIFO over an external byte-level
// SPI engine. Each frame starts on a rising edge of x4_isr_i while enabled.
// The reader then sends the FIFO read command (8'h80 | FIFO_ADDR) and pulls
// FRAME_BINS samples of three bytes each, MSB first. Each sample is packed as
// {b0,b1,b2}, a 24-bit two's complement value sign-extended to 25 bits, and
// emitted as a one-cycle strobe.
//
// Optional build macro: X4_OVERRUN_DET_EN adds overrun_cnt_o.
//
// Ports
//   clk_i              system clock, rising edge
//   rst_i              asynchronous active-high reset
//   enable_i           arms capture; only looked at while idle
//   x4_isr_i           asynchronous frame-ready from X4
//   spi_cs_o           active-low chip select, low for the whole burst
//   spi_tx_en_o        transmit-byte request
//   spi_rx_en_o        receive-byte request
//   spi_data_in_o      byte to transmit
//   spi_data_out_i     received byte
//   spi_tx_done_i      transmit byte complete
//   spi_rx_done_i      receive byte complete
//   x4data_valid_o     one-cycle sample strobe
//   x4data_data_o      signed 25-bit sample, held until the next strobe
//   frame_sop_o        first sample of the frame
//   frame_eop_o        last sample of the frame
//   x4data_isr2mcu_o   one-cycle frame-complete pulse
//   spi_err_o          one-cycle pulse when an SPI wait times out
//   busy_o             frame in progress
//   overrun_cnt_o      (X4_OVERRUN_DET_EN only) isr edges ignored while busy,
//                      saturates at 255
module x4_frame_reader #(
  parameter int unsigned FRAME_BINS = 188,
  parameter logic [7:0]  FIFO_ADDR  = 8'h31,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        x4_isr_i,
  output logic        spi_cs_o,
  output logic        spi_tx_en_o,
  output logic        spi_rx_en_o,
  output logic [7:0]  spi_data_in_o,
  input  logic [7:0]  spi_data_out_i,
  input  logic        spi_tx_done_i,
  input  logic        spi_rx_done_i,
  output logic        x4data_valid_o,
  output logic [24:0] x4data_data_o,
  output logic        frame_sop_o,
  output logic        frame_eop_o,
  output logic        x4data_isr2mcu_o,
  output logic        spi_err_o,
  output logic        busy_o
`ifdef X4_OVERRUN_DET_EN
  ,
  output logic [7:0]  overrun_cnt_o
`endif
);

  localparam int SW = (FRAME_BINS > 1) ? $clog2(FRAME_BINS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] LAST_SAMPLE = SW'(FRAME_BINS - 1);
  localparam logic [TW-1:0] TMO_LOAD    = TW'(TIMEOUT - 1);
  localparam logic [7:0]    READ_CMD    = 8'h80 | FIFO_ADDR;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_WAIT, S_RX, S_RX_WAIT, S_EMIT, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    isr_sync_q;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [SW-1:0] sample_cnt_q, sample_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   shift_q, shift_d;
  logic [24:0]   data_q, data_d;
  logic          err_q, err_d;
  logic          isr_rise;

  // Two flops synchronise, the third gives the previous value for the edge.
  assign isr_rise = isr_sync_q[1] & ~isr_sync_q[2];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      isr_sync_q   <= '0;
      byte_cnt_q   <= '0;
      sample_cnt_q <= '0;
      tmo_q        <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      isr_sync_q   <= {isr_sync_q[1:0], x4_isr_i};
      byte_cnt_q   <= byte_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      tmo_q        <= tmo_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    byte_cnt_d       = byte_cnt_q;
    sample_cnt_d     = sample_cnt_q;
    tmo_d            = tmo_q;
    shift_d          = shift_q;
    data_d           = data_q;
    err_d            = 1'b0;
    spi_cs_o         = 1'b1;
    spi_tx_en_o      = 1'b0;
    spi_rx_en_o      = 1'b0;
    spi_data_in_o    = 8'h00;
    x4data_valid_o   = 1'b0;
    frame_sop_o      = 1'b0;
    frame_eop_o      = 1'b0;
    x4data_isr2mcu_o = 1'b0;
    busy_o           = 1'b1;

    case (state_q)
      S_IDLE: begin
        busy_o       = 1'b0;
        byte_cnt_d   = '0;
        sample_cnt_d = '0;
        if (isr_rise && enable_i) state_d = S_ADDR;
      end
      S_ADDR: begin
        spi_cs_o      = 1'b0;
        spi_tx_en_o   = 1'b1;
        spi_data_in_o = READ_CMD;
        tmo_d         = TMO_LOAD;
        state_d       = S_ADDR_WAIT;
      end
      S_ADDR_WAIT: begin
        spi_cs_o      = 1'b0;
        spi_tx_en_o   = 1'b1;
        spi_data_in_o = READ_CMD;
        if (spi_tx_done_i) begin
          state_d = S_RX;
        end else if (tmo_q == '0) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      S_RX: begin
        spi_cs_o    = 1'b0;
        spi_rx_en_o = 1'b1;
        tmo_d       = TMO_LOAD;
        state_d     = S_RX_WAIT;
      end
      S_RX_WAIT: begin
        spi_cs_o    = 1'b0;
        spi_rx_en_o = 1'b1;
        if (spi_rx_done_i) begin
          if (byte_cnt_q == 2'd2) begin
            // b0 sits in shift_q[15:8]; its MSB is the sample sign.
            data_d     = {shift_q[15], shift_q, spi_data_out_i};
            byte_cnt_d = '0;
            state_d    = S_EMIT;
          end else begin
            shift_d    = {shift_q[7:0], spi_data_out_i};
            byte_cnt_d = byte_cnt_q + 1'b1;
            state_d    = S_RX;
          end
        end else if (tmo_q == '0) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      S_EMIT: begin
        spi_cs_o       = 1'b0;
        x4data_valid_o = 1'b1;
        frame_sop_o    = (sample_cnt_q == '0);
        frame_eop_o    = (sample_cnt_q == LAST_SAMPLE);
        if (sample_cnt_q == LAST_SAMPLE) begin
          state_d = S_DONE;
        end else begin
          sample_cnt_d = sample_cnt_q + 1'b1;
          state_d      = S_RX;
        end
      end
      S_DONE: begin
        x4data_isr2mcu_o = 1'b1;
        state_d          = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign x4data_data_o = data_q;
  assign spi_err_o     = err_q;

`ifdef X4_OVERRUN_DET_EN
  logic [7:0] ovr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovr_q <= '0;
    end else if (isr_rise && (state_q != S_IDLE) && (ovr_q != 8'hFF)) begin
      ovr_q <= ovr_q + 1'b1;
    end
  end

  assign overrun_cnt_o = ovr_q;
`endif

endmodule
